// File: rtl/game_pkg.sv
// Shared definitions for the rhythm-game session sequencer.
package game_pkg;

    // Session state encoding, exposed directly on the state output.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_RESULT    = 3'd4
    } game_state_e;

    // Seconds the result screen stays up before an automatic restart.
    localparam int unsigned RESULT_HOLD_S = 5;

endpackage

// File: rtl/game_flow_ctrl_btn_sync_edge.sv
// 2-FF synchronizer plus registered rising-edge detector for a raw button level.
// rise_o is one cycle wide, three cycles after the input edge.
module btn_sync_edge (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise_q,  rise_d;

    // Synchronizer chain and edge detect next-state.
    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise_d  = sync2_q & ~prev_q;
    end

    // Synchronizer and edge flops.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Session sequencer: IDLE -> COUNTDOWN -> PLAY <-> PAUSE -> RESULT.
// Optional macro AUTO_RESTART_EN: RESULT returns to IDLE after RESULT_HOLD_S seconds.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned COUNTDOWN_S = 3,
    parameter int unsigned SONG_BEATS  = 256,
    parameter int unsigned MISS_LIMIT  = 8
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic        beat_pulse,
    input  logic        miss_pulse,
    output logic        game_active,
    output logic        game_start,
    output logic [2:0]  state,
    output logic [3:0]  countdown_digit,
    output logic [15:0] beat_count,
    output logic [7:0]  miss_count,
    output logic        result_pass
);

    localparam int unsigned TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLK_HZ - 1);
    localparam logic [15:0] BEATS_END = 16'(SONG_BEATS);
    localparam logic [7:0]  MISS_END  = 8'(MISS_LIMIT);
    localparam logic [3:0]  CD_INIT   = 4'(COUNTDOWN_S);

    logic start_rise, pause_rise;

    game_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_q,  tick_d;
    logic [3:0]        digit_q, digit_d;
    logic [15:0]       beat_q,  beat_d;
    logic [7:0]        miss_q,  miss_d;
    logic              pass_q,  pass_d;
    logic              start_q, start_d;
`ifdef AUTO_RESTART_EN
    logic [2:0]        hold_q,  hold_d;
`endif

    logic [15:0] beat_inc;
    logic [7:0]  miss_inc;
    logic        tick_wrap;

    btn_sync_edge u_start_sync (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .btn_i   (start_btn),
        .rise_o  (start_rise)
    );

    btn_sync_edge u_pause_sync (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .btn_i   (pause_btn),
        .rise_o  (pause_rise)
    );

    // State and datapath registers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            digit_q <= '0;
            beat_q  <= '0;
            miss_q  <= '0;
            pass_q  <= 1'b0;
            start_q <= 1'b0;
`ifdef AUTO_RESTART_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            digit_q <= digit_d;
            beat_q  <= beat_d;
            miss_q  <= miss_d;
            pass_q  <= pass_d;
            start_q <= start_d;
`ifdef AUTO_RESTART_EN
            hold_q  <= hold_d;
`endif
        end
    end

    // Next-state: transitions, countdown ticking and event counting.
    always_comb begin
        beat_inc  = beat_q + 16'(beat_pulse);
        miss_inc  = (miss_q == 8'hff) ? miss_q : miss_q + 8'(miss_pulse);
        tick_wrap = (tick_q == TICK_MAX);

        state_d = state_q;
        tick_d  = '0;
        digit_d = digit_q;
        beat_d  = beat_q;
        miss_d  = miss_q;
        pass_d  = pass_q;
        start_d = 1'b0;
`ifdef AUTO_RESTART_EN
        hold_d  = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_COUNTDOWN;
                    digit_d = CD_INIT;
                    beat_d  = '0;
                    miss_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_COUNTDOWN: begin
                if (tick_wrap) begin
                    if (digit_q <= 4'd1) begin
                        state_d = ST_PLAY;
                        digit_d = '0;
                        start_d = 1'b1;
                    end else begin
                        digit_d = digit_q - 4'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_PLAY: begin
                beat_d = beat_inc;
                miss_d = miss_inc;
                // Miss limit outranks song completion; any exit outranks pause.
                if (miss_inc == MISS_END) begin
                    state_d = ST_RESULT;
                    pass_d  = 1'b0;
                end else if (beat_inc == BEATS_END) begin
                    state_d = ST_RESULT;
                    pass_d  = 1'b1;
                end else if (pause_rise) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start_rise) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                    miss_d  = '0;
                end else if (pause_rise) begin
                    state_d = ST_PLAY;
                end
            end
            ST_RESULT: begin
                if (start_rise) begin
                    state_d = ST_IDLE;
                end
`ifdef AUTO_RESTART_EN
                else if (tick_wrap) begin
                    if (hold_q == 3'(RESULT_HOLD_S - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                    hold_d = hold_q;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: direct register taps and a state decode.
    always_comb begin
        state           = state_q;
        game_active     = (state_q == ST_PLAY);
        game_start      = start_q;
        countdown_digit = digit_q;
        beat_count      = beat_q;
        miss_count      = miss_q;
        result_pass     = pass_q;
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a small-parameter build.
module tb_game_flow_ctrl;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic        start_btn, pause_btn, beat_pulse, miss_pulse;
    logic        game_active, game_start, result_pass;
    logic [2:0]  state;
    logic [3:0]  countdown_digit;
    logic [15:0] beat_count;
    logic [7:0]  miss_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        beat;
        logic        miss;
        logic [2:0]  st;
        logic [15:0] bc;
        logic [7:0]  mc;
        logic        pass;
        logic        act;
    } vec_t;

    vec_t vecs[17];

    game_flow_ctrl #(
        .CLK_HZ      (10),
        .COUNTDOWN_S (3),
        .SONG_BEATS  (4),
        .MISS_LIMIT  (2)
    ) dut (
        .clk_50m         (clk_50m),
        .rst_n           (rst_n),
        .start_btn       (start_btn),
        .pause_btn       (pause_btn),
        .beat_pulse      (beat_pulse),
        .miss_pulse      (miss_pulse),
        .game_active     (game_active),
        .game_start      (game_start),
        .state           (state),
        .countdown_digit (countdown_digit),
        .beat_count      (beat_count),
        .miss_count      (miss_count),
        .result_pass     (result_pass)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Button rise reaches the FSM on the fourth edge after the press.
    task automatic press_start();
        start_btn = 1'b1;
        repeat (4) step();
        start_btn = 1'b0;
    endtask

    task automatic press_pause();
        pause_btn = 1'b1;
        repeat (4) step();
        pause_btn = 1'b0;
    endtask

    task automatic wait_state(input string name, input logic [2:0] exp, input int bound);
        int n = 0;
        while (state !== exp && n < bound) begin
            step();
            n++;
        end
        check(name, 32'(state), 32'(exp));
    endtask

    task automatic start_game();
        repeat (4) step();
        press_start();
        check("sg_countdown", 32'(state), 32'd1);
        check("sg_bc_clr", 32'(beat_count), 32'd0);
        check("sg_mc_clr", 32'(miss_count), 32'd0);
        check("sg_pass_clr", 32'(result_pass), 32'd0);
        wait_state("sg_play", 3'd2, 40);
    endtask

    task automatic leave_result();
        repeat (4) step();
        press_start();
        check("result_exit", 32'(state), 32'd0);
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            beat_pulse = vecs[i].beat;
            miss_pulse = vecs[i].miss;
            step();
            beat_pulse = 1'b0;
            miss_pulse = 1'b0;
            check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("v%0d_beats", i), 32'(beat_count), 32'(vecs[i].bc));
            check($sformatf("v%0d_miss", i), 32'(miss_count), 32'(vecs[i].mc));
            check($sformatf("v%0d_pass", i), 32'(result_pass), 32'(vecs[i].pass));
            check($sformatf("v%0d_active", i), 32'(game_active), 32'(vecs[i].act));
        end
    endtask

    initial begin
        bit ok;

        //            beat  miss  st    bc     mc    pass  act
        vecs[0]  = '{1'b1, 1'b0, 3'd2, 16'd1, 8'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 3'd2, 16'd1, 8'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 3'd2, 16'd2, 8'd1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 3'd2, 16'd3, 8'd1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 3'd4, 16'd4, 8'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'd4, 16'd4, 8'd1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'd4, 16'd4, 8'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'd2, 16'd0, 8'd1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 3'd4, 16'd0, 8'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'd2, 16'd1, 8'd0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 3'd2, 16'd2, 8'd0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 3'd2, 16'd3, 8'd1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 3'd4, 16'd4, 8'd2, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 3'd2, 16'd1, 8'd0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 3'd3, 16'd2, 8'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 3'd3, 16'd2, 8'd0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 3'd2, 16'd2, 8'd1, 1'b0, 1'b1};

        rst_n = 1'b0;
        start_btn = 1'b0;
        pause_btn = 1'b0;
        beat_pulse = 1'b0;
        miss_pulse = 1'b0;
        repeat (3) step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_digit", 32'(countdown_digit), 32'd0);
        check("rst_beats", 32'(beat_count), 32'd0);
        check("rst_miss", 32'(miss_count), 32'd0);
        check("rst_active", 32'(game_active), 32'd0);
        check("rst_start", 32'(game_start), 32'd0);
        check("rst_pass", 32'(result_pass), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Countdown: 10 cycles per digit, PLAY and game_start on the 30th.
        press_start();
        check("cd_enter", 32'(state), 32'd1);
        check("cd_digit3", 32'(countdown_digit), 32'd3);
        for (int k = 1; k <= 31; k++) begin
            step();
            check($sformatf("cd_digit_k%0d", k), 32'(countdown_digit),
                  (k < 30) ? 32'(3 - k / 10) : 32'd0);
            check($sformatf("cd_state_k%0d", k), 32'(state), (k < 30) ? 32'd1 : 32'd2);
            check($sformatf("cd_gstart_k%0d", k), 32'(game_start), (k == 30) ? 32'd1 : 32'd0);
            if (k == 30) check("play_active", 32'(game_active), 32'd1);
        end

        // Song completion, then RESULT hold behaviour.
        apply_vecs(0, 6);
        ok = 1'b1;
`ifdef AUTO_RESTART_EN
        for (int i = 3; i <= 49; i++) begin
            step();
            if (state !== 3'd4) ok = 1'b0;
        end
        check("result_timer_hold", 32'(ok), 32'd1);
        step();
        check("auto_restart_idle", 32'(state), 32'd0);
`else
        repeat (200) begin
            step();
            if (state !== 3'd4) ok = 1'b0;
        end
        check("result_hold_200", 32'(ok), 32'd1);
        check("result_pass_hold", 32'(result_pass), 32'd1);
        leave_result();
`endif

        // Miss limit abort.
        start_game();
        apply_vecs(7, 8);
        leave_result();

        // Beat limit and miss limit together: miss limit wins.
        start_game();
        apply_vecs(9, 12);
        leave_result();

        // Pause: beat in the pause_rise cycle still counts, then events ignored.
        start_game();
        apply_vecs(13, 13);
        pause_btn = 1'b1;
        repeat (3) step();
        beat_pulse = 1'b1;
        step();
        beat_pulse = 1'b0;
        pause_btn = 1'b0;
        check("pause_enter", 32'(state), 32'd3);
        check("pause_beat_same_cycle", 32'(beat_count), 32'd2);
        apply_vecs(14, 15);
        repeat (4) step();
        ok = 1'b1;
        pause_btn = 1'b1;
        repeat (4) begin
            step();
            if (game_start !== 1'b0) ok = 1'b0;
        end
        pause_btn = 1'b0;
        check("resume_play", 32'(state), 32'd2);
        check("resume_no_gstart", 32'(ok), 32'd1);
        apply_vecs(16, 16);
        repeat (4) step();
        press_pause();
        check("pause_again", 32'(state), 32'd3);
        repeat (4) step();
        press_start();
        check("abort_idle", 32'(state), 32'd0);
        check("abort_beats", 32'(beat_count), 32'd0);
        check("abort_miss", 32'(miss_count), 32'd0);

        // Asynchronous reset in the middle of the countdown.
        repeat (4) step();
        press_start();
        repeat (15) step();
        check("mid_cd_state", 32'(state), 32'd1);
        rst_n = 1'b0;
        #2;
        check("arst_state", 32'(state), 32'd0);
        check("arst_digit", 32'(countdown_digit), 32'd0);
        check("arst_active", 32'(game_active), 32'd0);
        check("arst_start", 32'(game_start), 32'd0);
        check("arst_beats", 32'(beat_count), 32'd0);
        check("arst_miss", 32'(miss_count), 32'd0);
        check("arst_pass", 32'(result_pass), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_idle", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level session sequencer for the rhythm game. Turns the raw start/pause buttons and datapath event pulses into a single game_active enable and a start strobe for the sync, rhythm, note-generation and scoring blocks. Runs a countdown, tracks the beat position and misses, ends the song on completion or miss limit, and reports pass/fail. Sits beside the sync controller in the top level, all on clk_50m.

Parameters:
CLK_HZ, 50000000, cycles per one-second countdown tick
COUNTDOWN_S, 3, countdown length in seconds (1..9)
SONG_BEATS, 256, beats until the song ends
MISS_LIMIT, 8, misses that abort the song (1..255)

Ports:
clk_50m  in  1  system clock
rst_n  in  1  async active-low reset
start_btn  in  1  raw start button, level, asynchronous to clk_50m
pause_btn  in  1  raw pause button, level, asynchronous to clk_50m
beat_pulse  in  1  one-cycle beat strobe from the sync controller
miss_pulse  in  1  one-cycle miss strobe from game logic
game_active  out  1  high only in PLAY
game_start  out  1  one-cycle strobe on COUNTDOWN->PLAY
state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, RESULT=4
countdown_digit  out  4  remaining seconds in COUNTDOWN, else 0
beat_count  out  16  beats elapsed in the current song
miss_count  out  8  misses in the current song, saturating at 255
result_pass  out  1  valid in RESULT: 1 = song completed, 0 = aborted

Behaviour:
- Reset is rst_n (asynchronous, active-low); clock is clk_50m. On reset: state=IDLE, all outputs 0, all counters 0.
- Button inputs: each goes through a 2-FF synchronizer, then rising-edge detection. This gives start_rise and pause_rise, each one cycle wide, 3 cycles after the input edge.
- IDLE:
  - On start_rise: go to COUNTDOWN, countdown_digit=COUNTDOWN_S, tick counter=0, beat_count=0, miss_count=0, result_pass=0.
- COUNTDOWN:
  - Tick counter counts 0..CLK_HZ-1; at wrap, countdown_digit decrements.
  - When countdown_digit would go from 1 to 0: go to PLAY. In that same cycle, game_start=1 for exactly one cycle.
  - start_rise and pause_rise are ignored.
- PLAY:
  - game_active=1.
  - beat_pulse increments beat_count.
  - miss_pulse increments miss_count, saturating at 255.
  - Exit to RESULT when, after the increment, beat_count==SONG_BEATS (result_pass=1) or miss_count==MISS_LIMIT (result_pass=0).
  - If both conditions are met in the same cycle, the miss limit wins: result_pass=0.
  - pause_rise goes to PAUSE; a beat/miss arriving in that same cycle is still counted first.
  - If an exit condition and pause_rise occur in the same cycle, RESULT wins.
- PAUSE:
  - game_active=0; beat_pulse and miss_pulse are ignored; counters hold.
  - pause_rise returns to PLAY (no game_start strobe).
  - start_rise aborts to IDLE and clears the counters.
- RESULT:
  - game_active=0; counters and result_pass hold.
  - start_rise goes to IDLE (see Optional Feature).
- Undefined state encodings return to IDLE on the next cycle.
- Tick counter width: clog2(CLK_HZ). Compare beat_count against SONG_BEATS at 16 bits.
- Latency: outputs are registered; state outputs change the cycle after the causing event.

Optional Feature:
AUTO_RESTART_EN
- Defined: RESULT runs a 5 s timer on the tick counter (5*CLK_HZ cycles) and then returns to IDLE automatically. start_rise during RESULT still exits to IDLE immediately.
- Undefined: RESULT holds until start_rise; no timer logic is synthesized.

Decomposition:
- Shared package game_pkg:
  - state encoding constants: ST_IDLE, ST_COUNTDOWN, ST_PLAY, ST_PAUSE, ST_RESULT
  - RESULT_HOLD_S=5
- One sub-module, btn_sync_edge: 2-FF synchronizer plus rising-edge detector, instantiated twice (start, pause).
- The FSM, tick counter and event counters stay in game_flow_ctrl.

Test Plan:
All scenarios use CLK_HZ=10, COUNTDOWN_S=3, SONG_BEATS=4, MISS_LIMIT=2.
- Start from IDLE -> COUNTDOWN, countdown_digit=3, then 2 and 1 at 10-cycle steps; game_start high 1 cycle at ~30 cycles; state=2; game_active=1.
- 4 beat_pulses in PLAY -> beat_count=4, state=RESULT, result_pass=1, game_active=0.
- 2 miss_pulses in PLAY -> miss_count=2, RESULT, result_pass=0; in a separate run, beat 4 and miss 2 in the same cycle -> result_pass=0.
- pause_rise in PLAY, then beats and misses -> counters unchanged, game_active=0; second pause_rise -> PLAY, no game_start; start_rise while paused -> IDLE, counters 0.
- Assert rst_n mid-COUNTDOWN -> all outputs 0 immediately, state=IDLE.
- With AUTO_RESTART_EN defined, RESULT -> IDLE after 50 cycles; without it, RESULT holds for 200 cycles until start_rise.
